// File: rtl/bounce_updater_n_if.sv
// bounce_updater_n_if: frame-control, key, colour and game-state bundle
// between the game controller (master) and bounce_updater_n (slave).
interface bounce_updater_n_if #(
    parameter int NUM_PLATS = 4,
    parameter int POS_W     = 8,
    parameter int COLOR_W   = 3,
    parameter int SCORE_W   = 32
);
    logic                         tick;
    logic                         start;
    logic [NUM_PLATS-1:0]         keys;
    logic [NUM_PLATS*POS_W-1:0]   plat_pos;
    logic [COLOR_W-1:0]           rand_ball;
    logic [NUM_PLATS*COLOR_W-1:0] rand_plats;
    logic [POS_W-1:0]             ball_pos;
    logic [POS_W-1:0]             prev_ball_pos;
    logic [COLOR_W-1:0]           ball_color;
    logic [NUM_PLATS*COLOR_W-1:0] plat_color;
    logic [SCORE_W-1:0]           score;
    logic                         hit;
    logic                         gameover;
    logic [1:0]                   lives;

    modport master (
        output tick, start, keys, plat_pos, rand_ball, rand_plats,
        input  ball_pos, prev_ball_pos, ball_color, plat_color,
        input  score, hit, gameover, lives
    );

    modport slave (
        input  tick, start, keys, plat_pos, rand_ball, rand_plats,
        output ball_pos, prev_ball_pos, ball_color, plat_color,
        output score, hit, gameover, lives
    );
endinterface

// File: rtl/bounce_updater_n.sv
// bounce_updater_n: per-frame ball/platform/score updater for colour-bounce.
// Optional LIVES_EN: multi-life play, respawn at SPAWN_Y on floor contact.
module bounce_updater_n #(
    parameter int NUM_PLATS    = 4,
    parameter int POS_W        = 8,
    parameter int COLOR_W      = 3,
    parameter int SCORE_W      = 32,
    parameter int BOUNCE_TICKS = 50,
    parameter int HIT_WINDOW   = 4,
    parameter int FLOOR_Y      = 116,
    parameter int SPAWN_Y      = 0,
    parameter int NUM_LIVES    = 3
) (
    input logic               clk,
    input logic               resetn,
    bounce_updater_n_if.slave bus
);
    localparam int CNT_W = $clog2(BOUNCE_TICKS + 1);
    localparam int EXT_W = POS_W + 1;
    localparam int PC_W  = NUM_PLATS * COLOR_W;

`ifdef LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'(NUM_LIVES);
`else
    localparam logic [1:0] LIVES_INIT = 2'd0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FALL,
        S_RISE,
        S_OVER
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [POS_W-1:0]     r_ball;
    logic [POS_W-1:0]     w_ball_nx;
    logic [POS_W-1:0]     r_prev;
    logic [POS_W-1:0]     w_prev_nx;
    logic [COLOR_W-1:0]   r_bcol;
    logic [COLOR_W-1:0]   w_bcol_nx;
    logic [PC_W-1:0]      r_pcol;
    logic [PC_W-1:0]      w_pcol_nx;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   w_score_nx;
    logic                 r_hit;
    logic                 w_hit_nx;
    logic [CNT_W-1:0]     r_up;
    logic [CNT_W-1:0]     w_up_nx;
    logic [1:0]           r_lives;
    logic [1:0]           w_lives_nx;
    logic [NUM_PLATS-1:0] r_keys;
    logic [NUM_PLATS-1:0] r_pend;
    logic [NUM_PLATS-1:0] w_pend_nx;

    logic [NUM_PLATS-1:0] w_fall;
    logic [NUM_PLATS-1:0] w_pend_eff;
    logic [POS_W-1:0]     w_sel_pos;
    logic [COLOR_W-1:0]   w_sel_col;
    logic [EXT_W-1:0]     w_ball_ext;
    logic [EXT_W-1:0]     w_plat_ext;
    logic [EXT_W-1:0]     w_up_pos;
    logic [EXT_W-1:0]     w_dn_pos;
    logic [EXT_W-1:0]     w_new_pos;
    logic                 w_hit_ok;

    // Pressed key selection, hit window test and candidate ball moves.
    always_comb begin
        w_fall     = r_keys & ~bus.keys;
        w_pend_eff = r_pend | w_fall;
        w_sel_pos  = '0;
        w_sel_col  = '0;
        for (int i = 0; i < NUM_PLATS; i++) begin
            if (w_pend_eff[i]) begin
                w_sel_pos = bus.plat_pos[i*POS_W +: POS_W];
                w_sel_col = r_pcol[i*COLOR_W +: COLOR_W];
            end
        end
        w_ball_ext = {1'b0, r_ball};
        w_plat_ext = {1'b0, w_sel_pos};
        w_hit_ok   = $onehot(w_pend_eff)
                   && (r_bcol == w_sel_col)
                   && (w_plat_ext >= w_ball_ext)
                   && (w_plat_ext <= w_ball_ext + EXT_W'(HIT_WINDOW));
        w_up_pos   = (r_ball == '0) ? '0 : w_ball_ext - EXT_W'(1);
        w_dn_pos   = w_ball_ext + EXT_W'(1);
    end

    // Next state and next game values for start and tick events.
    always_comb begin
        w_state_nx = r_state;
        w_ball_nx  = r_ball;
        w_prev_nx  = r_prev;
        w_bcol_nx  = r_bcol;
        w_pcol_nx  = r_pcol;
        w_score_nx = r_score;
        w_hit_nx   = 1'b0;
        w_up_nx    = r_up;
        w_lives_nx = r_lives;
        w_pend_nx  = w_pend_eff;
        w_new_pos  = w_ball_ext;
        unique case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    w_ball_nx  = POS_W'(SPAWN_Y);
                    w_prev_nx  = POS_W'(SPAWN_Y);
                    w_score_nx = '0;
                    w_bcol_nx  = bus.rand_ball;
                    w_pcol_nx  = bus.rand_plats;
                    w_lives_nx = LIVES_INIT;
                    w_up_nx    = '0;
                    w_pend_nx  = '0;
                    w_state_nx = S_FALL;
                end
            end
            S_FALL, S_RISE: begin
                if (bus.tick) begin
                    w_pend_nx = '0;
                    w_prev_nx = r_ball;
                    if (w_hit_ok) begin
                        w_hit_nx   = 1'b1;
                        w_bcol_nx  = bus.rand_ball;
                        w_pcol_nx  = bus.rand_plats;
                        if (r_score != '1) begin
                            w_score_nx = r_score + SCORE_W'(1);
                        end
                        w_up_nx    = CNT_W'(BOUNCE_TICKS - 1);
                        w_new_pos  = w_up_pos;
                        w_state_nx = S_RISE;
                    end else if (r_state == S_FALL) begin
                        w_new_pos = w_dn_pos;
                    end else if (r_up == '0) begin
                        w_new_pos  = w_dn_pos;
                        w_state_nx = S_FALL;
                    end else begin
                        w_new_pos = w_up_pos;
                        w_up_nx   = r_up - CNT_W'(1);
                    end
                    if (w_new_pos >= EXT_W'(FLOOR_Y)) begin
`ifdef LIVES_EN
                        if (r_lives > 2'd1) begin
                            w_lives_nx = r_lives - 2'd1;
                            w_ball_nx  = POS_W'(SPAWN_Y);
                            w_up_nx    = '0;
                            w_state_nx = S_FALL;
                        end else begin
                            w_lives_nx = 2'd0;
                            w_ball_nx  = POS_W'(FLOOR_Y);
                            w_state_nx = S_OVER;
                        end
`else
                        w_ball_nx  = POS_W'(FLOOR_Y);
                        w_state_nx = S_OVER;
`endif
                    end else begin
                        w_ball_nx = w_new_pos[POS_W-1:0];
                    end
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Game data registers and key edge capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ball  <= POS_W'(SPAWN_Y);
            r_prev  <= POS_W'(SPAWN_Y);
            r_bcol  <= '0;
            r_pcol  <= '0;
            r_score <= '0;
            r_hit   <= 1'b0;
            r_up    <= '0;
            r_lives <= LIVES_INIT;
            r_keys  <= '1;
            r_pend  <= '0;
        end else begin
            r_ball  <= w_ball_nx;
            r_prev  <= w_prev_nx;
            r_bcol  <= w_bcol_nx;
            r_pcol  <= w_pcol_nx;
            r_score <= w_score_nx;
            r_hit   <= w_hit_nx;
            r_up    <= w_up_nx;
            r_lives <= w_lives_nx;
            r_keys  <= bus.keys;
            r_pend  <= w_pend_nx;
        end
    end

    assign bus.ball_pos      = r_ball;
    assign bus.prev_ball_pos = r_prev;
    assign bus.ball_color    = r_bcol;
    assign bus.plat_color    = r_pcol;
    assign bus.score         = r_score;
    assign bus.hit           = r_hit;
    assign bus.gameover      = (r_state == S_OVER);
    assign bus.lives         = r_lives;
endmodule

// File: tb/tb_bounce_updater_n.sv
// tb_bounce_updater_n: directed and randomized check of bounce_updater_n
// against a behavioural game model.
module tb_bounce_updater_n;
    localparam int NP = 4;
    localparam int PW = 8;
    localparam int CW = 3;
    localparam int SW = 32;
    localparam int BT = 50;
    localparam int HW = 4;
    localparam int FY = 116;
    localparam int SY = 0;
`ifdef LIVES_EN
    localparam int NL = 3;
`else
    localparam int NL = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;

    bounce_updater_n_if #(
        .NUM_PLATS(NP), .POS_W(PW), .COLOR_W(CW), .SCORE_W(SW)
    ) bus ();

    bounce_updater_n dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // behavioural model: 0 idle, 1 falling, 2 rising, 3 over
    int m_st, m_ball, m_prev, m_bcol, m_up, m_lives, m_hit;
    int m_pcol [NP];
    longint m_score;
    logic [NP-1:0] m_pend, m_kq;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_ball = SY; m_prev = SY; m_bcol = 0;
        m_score = 0; m_hit = 0; m_up = 0; m_lives = NL;
        m_pend = '0; m_kq = '1;
        for (int i = 0; i < NP; i++) m_pcol[i] = 0;
    endtask

    task automatic model_step();
        logic [NP-1:0] eff;
        int k, np, pp;
        bit h;
        eff = m_pend | (m_kq & ~bus.keys);
        m_kq = bus.keys;
        m_hit = 0;
        if (m_st == 0 || m_st == 3) begin
            m_pend = eff;
            if (bus.start) begin
                m_ball = SY; m_prev = SY; m_score = 0;
                m_bcol = int'(bus.rand_ball);
                for (int i = 0; i < NP; i++)
                    m_pcol[i] = int'(bus.rand_plats[i*CW +: CW]);
                m_lives = NL; m_up = 0; m_pend = '0; m_st = 1;
            end
        end else if (!bus.tick) begin
            m_pend = eff;
        end else begin
            m_pend = '0;
            m_prev = m_ball;
            k = -1;
            if ($countones(eff) == 1)
                for (int i = 0; i < NP; i++) if (eff[i]) k = i;
            h = 1'b0;
            if (k >= 0) begin
                pp = int'(bus.plat_pos[k*PW +: PW]);
                h = (m_bcol == m_pcol[k]) && (m_ball <= pp)
                    && (pp <= m_ball + HW);
            end
            if (h) begin
                m_hit = 1;
                m_bcol = int'(bus.rand_ball);
                for (int i = 0; i < NP; i++)
                    m_pcol[i] = int'(bus.rand_plats[i*CW +: CW]);
                if (m_score < ((longint'(1) << SW) - 1)) m_score++;
                m_up = BT - 1;
                np = (m_ball > 0) ? m_ball - 1 : 0;
                m_st = 2;
            end else if (m_st == 1) begin
                np = m_ball + 1;
            end else if (m_up == 0) begin
                np = m_ball + 1;
                m_st = 1;
            end else begin
                np = (m_ball > 0) ? m_ball - 1 : 0;
                m_up--;
            end
            if (np >= FY) begin
                if (m_lives > 1) begin
                    m_lives--; m_ball = SY; m_up = 0; m_st = 1;
                end else begin
                    m_lives = 0; m_ball = FY; m_st = 3;
                end
            end else begin
                m_ball = np;
            end
        end
    endtask

    // every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ball_pos", bus.ball_pos, m_ball);
            chk("prev_ball_pos", bus.prev_ball_pos, m_prev);
            chk("ball_color", bus.ball_color, m_bcol);
            chk("score", bus.score, m_score);
            chk("hit", bus.hit, m_hit);
            chk("gameover", bus.gameover, (m_st == 3) ? 1 : 0);
            chk("lives", bus.lives, m_lives);
            for (int i = 0; i < NP; i++)
                chk("plat_color", bus.plat_color[i*CW +: CW], m_pcol[i]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (resetn) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_tick(int n);
        repeat (n) begin
            bus.tick = 1'b1; cyc();
            bus.tick = 1'b0; cyc();
        end
    endtask

    task automatic do_start(int rb, logic [NP*CW-1:0] rp);
        bus.rand_ball = CW'(rb);
        bus.rand_plats = rp;
        bus.start = 1'b1; cyc();
        bus.start = 1'b0; cyc();
    endtask

    task automatic press(logic [NP-1:0] m);
        bus.keys = ~m; cyc();
        bus.keys = '1; cyc();
    endtask

    task automatic hard_reset();
        resetn = 1'b0;
        model_reset();
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    function automatic logic [NP*CW-1:0] pk(int c0, int c1, int c2, int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    function automatic logic [NP*PW-1:0] pp4(int p0, int p1, int p2, int p3);
        return {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endfunction

    initial begin
        int v;
        bus.tick = 1'b0; bus.start = 1'b0; bus.keys = '1;
        bus.rand_ball = '0; bus.rand_plats = '0;
        bus.plat_pos = pp4(200, 200, 12, 200);
        model_reset();
        #1;
        chk_en = 1'b1;
        hard_reset();

        // reset values and ignored tick in idle
        chk("rst_ball", bus.ball_pos, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_lives", bus.lives, NL);
        do_tick(2);
        chk("idle_tick_ball", bus.ball_pos, 0);

        // start and five plain falls
        do_start(3, pk(1, 2, 3, 4));
        do_tick(5);
        chk("fall5_ball", bus.ball_pos, 5);
        chk("fall5_prev", bus.prev_ball_pos, 4);
        chk("fall5_model", m_ball, 5);
        do_start(6, pk(0, 0, 0, 0));
        chk("start_ignored_col", bus.ball_color, 3);

        // hit at ball 10, platform 2 at 12
        do_tick(5);
        press(4'b0100);
        bus.rand_ball = 3'd5; bus.rand_plats = pk(5, 6, 7, 1);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        chk("hit_pulse", bus.hit, 1);
        chk("hit_ball", bus.ball_pos, 9);
        chk("hit_score", bus.score, 1);
        chk("hit_col", bus.ball_color, 5);
        chk("hit_model_ball", m_ball, 9);
        cyc();
        chk("hit_drop", bus.hit, 0);
        do_tick(49);
        chk("rise_top", bus.ball_pos, 0);
        do_tick(1);
        chk("rise_end", bus.ball_pos, 1);

        // colour mismatch miss
        hard_reset();
        do_start(3, pk(1, 2, 4, 4));
        do_tick(10);
        press(4'b0100);
        do_tick(1);
        chk("mismatch_ball", bus.ball_pos, 11);
        chk("mismatch_score", bus.score, 0);

        // outside window, then exactly at the window edge
        hard_reset();
        bus.plat_pos = pp4(200, 200, 15, 200);
        do_start(3, pk(1, 2, 3, 4));
        do_tick(10);
        press(4'b0100);
        do_tick(1);
        chk("window_miss", bus.ball_pos, 11);
        bus.rand_ball = 3'd3; bus.rand_plats = pk(1, 2, 3, 4);
        press(4'b0100);
        do_tick(1);
        chk("window_edge_ball", bus.ball_pos, 10);
        chk("window_edge_score", bus.score, 1);

        // two keys together miss, held key hits once
        hard_reset();
        bus.plat_pos = pp4(10, 11, 200, 200);
        do_start(3, pk(3, 3, 0, 0));
        do_tick(10);
        press(4'b0011);
        do_tick(1);
        chk("multi_key_ball", bus.ball_pos, 11);
        bus.plat_pos = pp4(12, 200, 200, 200);
        bus.rand_ball = 3'd3; bus.rand_plats = pk(3, 3, 0, 0);
        bus.keys = 4'b1110;
        do_tick(3);
        bus.keys = '1;
        chk("held_score", bus.score, 1);
        chk("held_ball", bus.ball_pos, 8);

        // floor contact
        hard_reset();
        bus.plat_pos = pp4(200, 200, 200, 200);
        do_start(2, pk(1, 1, 1, 1));
        do_tick(115);
        chk("pre_floor", bus.gameover, 0);
        do_tick(1);
`ifdef LIVES_EN
        chk("life1_ball", bus.ball_pos, 0);
        chk("life1_lives", bus.lives, 2);
        do_tick(116);
        chk("life2_lives", bus.lives, 1);
        do_tick(116);
        chk("life3_lives", bus.lives, 0);
`endif
        chk("floor_ball", bus.ball_pos, FY);
        chk("floor_prev", bus.prev_ball_pos, FY - 1);
        chk("floor_over", bus.gameover, 1);
        do_tick(3);
        chk("over_hold", bus.ball_pos, FY);
        do_start(1, pk(2, 2, 2, 2));
        chk("restart_ball", bus.ball_pos, 0);
        chk("restart_over", bus.gameover, 0);

        // asynchronous reset during rise
        hard_reset();
        bus.plat_pos = pp4(200, 200, 12, 200);
        do_start(3, pk(1, 2, 3, 4));
        do_tick(10);
        press(4'b0100);
        do_tick(3);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("areset_ball", bus.ball_pos, 0);
        chk("areset_score", bus.score, 0);
        chk("areset_col", bus.ball_color, 0);
        chk("areset_pcol", bus.plat_color, 0);
        cyc();
        resetn = 1'b1;
        cyc();

        // randomized play
        for (int c = 0; c < 4000; c++) begin
            bus.tick = ($urandom_range(0, 2) == 0);
            bus.start = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < NP; i++)
                    bus.keys[i] = ($urandom_range(0, 5) != 0);
            bus.rand_ball = CW'($urandom_range(0, 1));
            for (int i = 0; i < NP; i++) begin
                bus.rand_plats[i*CW +: CW] = CW'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) begin
                    v = m_ball + int'($urandom_range(0, 6)) - 1;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                end else begin
                    v = int'($urandom_range(0, 255));
                end
                bus.plat_pos[i*PW +: PW] = PW'(v);
            end
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                model_reset();
            end else begin
                resetn = 1'b1;
            end
            cyc();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bounce_updater_n.md
Name: bounce_updater_n

Overview:
Parametrised per-frame game-state updater for the colour-bounce game. It owns the ball position, ball colour, platform colours, score and game-over state, and advances them one step on each frame tick from the controller. It generalises the fixed 4-platform updater with NUM_PLATS platforms, configurable widths, bounce height and hit window. It adds an explicit FSM, key edge-capture, score saturation and a restart path. Random colours come from an external source, which is advanced by the hit pulse.

Parameters:
NUM_PLATS, 4, number of platforms/keys
POS_W, 8, ball/platform vertical position width
COLOR_W, 3, colour code width
SCORE_W, 32, score width
BOUNCE_TICKS, 50, ticks of upward travel after a hit
HIT_WINDOW, 4, ball-to-platform vertical tolerance
FLOOR_Y, 116, position at or beyond which the ball is lost
SPAWN_Y, 0, ball position on start/respawn
NUM_LIVES, 3, lives (used only with LIVES_EN)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
tick  in  1  one-clk frame-update strobe
start  in  1  begin/restart game
keys  in  NUM_PLATS  active-low buttons; bit i = platform i
plat_pos  in  NUM_PLATS*POS_W  platform positions, platform i at [i*POS_W +: POS_W]
rand_ball  in  COLOR_W  random ball colour
rand_plats  in  NUM_PLATS*COLOR_W  random platform colours
ball_pos  out  POS_W  current ball position
prev_ball_pos  out  POS_W  ball position before last tick (for erase)
ball_color  out  COLOR_W  current ball colour
plat_color  out  NUM_PLATS*COLOR_W  current platform colours
score  out  SCORE_W  hits this game
hit  out  1  one-clk pulse on successful hit
gameover  out  1  high in OVER state
lives  out  2  remaining lives (0 when LIVES_EN undefined)

Behaviour:
- Reset values: state IDLE; ball_pos=prev_ball_pos=SPAWN_Y; ball_color=0; plat_color=0; score=0; hit=0; gameover=0; up_cnt=0; pending=0. lives=NUM_LIVES with LIVES_EN, else 0. Reset mid-game aborts immediately.
- States: IDLE, FALL, RISE, OVER.
- IDLE/OVER + start: ball_pos=prev_ball_pos=SPAWN_Y, score=0, ball_color=rand_ball, plat_color=rand_plats, lives reloaded, up_cnt=0, pending cleared. Next state FALL. tick is ignored in IDLE/OVER. start is ignored in FALL/RISE.
- Key capture: keys are registered every clk. A 1->0 transition on bit i sets pending[i]. pending is cleared on every processed tick. Held keys do not retrigger.
- On tick in FALL/RISE, all updates occur on the same clk edge:
  - press valid iff exactly one pending bit (or a same-clk new falling edge) is set; multiple bits count as a miss.
  - hit iff press valid on i AND ball_color==plat_color[i] AND ball_pos <= plat_pos[i] <= ball_pos+HIT_WINDOW. The compare is done at POS_W+1 bits, with no wrap.
  - On hit: hit=1 for one clk; ball_color<=rand_ball; plat_color<=rand_plats; score+1, saturating at all-ones; up_cnt=BOUNCE_TICKS-1; ball moves up this tick; next state RISE. A hit in RISE reloads up_cnt.
  - No hit, FALL: ball+1.
  - No hit, RISE: ball-1 (saturates at 0), up_cnt-1. When up_cnt was 0, move down instead and go to FALL.
  - prev_ball_pos <= old ball_pos on every processed tick.
  - If the new position is >= FLOOR_Y: ball_pos=FLOOR_Y, then OVER with gameover=1 (see LIVES_EN).
- A hit and a floor crossing cannot coincide, because a hit always moves the ball up.
- Latency: outputs update on the clk edge that samples tick, so they are valid the cycle after tick.

Optional Feature:
LIVES_EN.
- Defined: floor contact with lives>1 decrements lives, sets ball_pos=SPAWN_Y, up_cnt=0, stays FALL, and keeps score/colours. Floor contact with lives==1 sets lives=0 and enters OVER.
- Undefined: the first floor contact enters OVER; lives is tied to 0.

Test Plan:
- Reset, start, 5 ticks with no keys -> ball_pos=5, prev_ball_pos=4, state FALL, score=0.
- ball_pos=10, plat_pos[2]=12, colours match, key2 pressed, tick -> hit pulse 1 clk; score=1; ball_pos=9; colours reloaded from rand inputs; 49 further ticks rise, then ball descends.
- Same setup with colour mismatch, or plat_pos[2]=15 (outside window) -> no hit; ball_pos=11.
- key0 and key1 pressed together, both matching -> miss; key held low over 3 ticks -> at most one hit.
- Ball falls from 110 with no hits -> on the 6th tick ball_pos=116, gameover=1; further ticks cause no change; start -> ball_pos=0, score=0, gameover=0.
- resetn pulsed low during RISE -> all outputs return to reset values asynchronously. With LIVES_EN, three floor contacts -> lives 2, 1, then OVER.
